seq_rotator_lr: RTL and testbench
=================================

SEQ_ROTATOR_LR -- requirements
Module: seq_rotator_lr

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning data width in bits.
REQ-002 The block SHALL have parameter M, default 3, meaning rotate-amount width in bits, with N = 2^M.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  request to begin an operation, sampled only when ready=1.
REQ-006 The block SHALL have port a  input  N  operand, captured on the accepted start.
REQ-007 The block SHALL have port amt  input  M  rotate distance 0..N-1, captured on the accepted start.
REQ-008 The block SHALL have port lr  input  1  direction, captured on the accepted start; 1 = rotate left, 0 = rotate right.
REQ-009 The block SHALL have port y  output  N  result register, driven directly from a flop.
REQ-010 The block SHALL have port ready  output  1  high while idle and able to accept start.
REQ-011 The block SHALL have port done_tick  output  1  one-cycle pulse marking a valid result on y.

Function
REQ-012 The block SHALL implement three states: IDLE, SHIFT, DONE.
REQ-013 ready SHALL be 1 exactly when state = IDLE.
REQ-014 In IDLE with start=1 at a rising edge, the block SHALL load y<=a, count<=amt, dir<=lr, and go to SHIFT if amt!=0, else to DONE.
REQ-015 In IDLE with start=0, the block SHALL hold y, count and dir unchanged.
REQ-016 In SHIFT, each rising edge SHALL rotate y by one position in the captured direction, with no bit lost: left is y<={y[N-2:0],y[N-1]}; right is y<={y[0],y[N-1:1]}.
REQ-017 In SHIFT, count SHALL decrement by one per edge; the edge on which count=1 SHALL perform the final rotate and move to DONE.
REQ-018 In DONE, done_tick SHALL be 1 for exactly that cycle, and the next edge SHALL return to IDLE; done_tick SHALL be 0 in every other state.
REQ-019 Latency SHALL be fixed: start accepted at edge t means done_tick is high in the cycle after edge t+amt, i.e. amt+1 cycles; amt=0 gives 1 cycle.
REQ-020 Final y SHALL equal a rotated by amt in direction lr, and SHALL be held through DONE and IDLE until the next accepted start.
REQ-021 start while ready=0 (SHIFT or DONE) SHALL be ignored, with no effect on state, y, count or the latency of the current operation.
REQ-022 Changes on a, amt or lr after capture SHALL have no effect on the operation in flight.
REQ-023 start asserted continuously SHALL begin a new operation on the first edge after DONE returns to IDLE, giving back-to-back operations separated by one IDLE cycle.

Reset
REQ-024 reset=1 SHALL, without waiting for a clock edge, force state=IDLE, y=0, count=0, dir=0, ready=1, done_tick=0.
REQ-025 reset during SHIFT or DONE SHALL abandon the operation, with no done_tick produced for it.
REQ-026 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-027 Bench SHALL check: a=0x96, amt=3, lr=0, start at edge t -> ready=0 from t, done_tick high only in the cycle after t+3, y=0xD2.
REQ-028 Bench SHALL check: a=0x96, amt=3, lr=1 -> done_tick after 4 cycles, y=0xB4.
REQ-029 Bench SHALL check: a=0x96, amt=0, lr=x -> done_tick in the cycle after the start edge, y=0x96, no SHIFT cycle.
REQ-030 Bench SHALL check: a=0x96, amt=7, lr=1 -> done_tick after 8 cycles, y=0x4B; a new start with a=0xFF, amt=5 applied during SHIFT is ignored (y stays 0x4B, no extra done_tick).
REQ-031 Bench SHALL check: reset pulsed two cycles into amt=6 -> y=0, ready=1 immediately, no done_tick; then a=0x01, amt=1, lr=1 -> y=0x02 after 2 cycles.
REQ-032 Bench SHALL check: start held high with random a/amt/lr for 1000 operations -> every y matches a reference rotate, and the IDLE gap between operations is exactly 1 cycle.

Source files
------------

// File: rtl/seq_rotator_lr.sv
// Sequential rotator: rotates an N-bit operand left or right by one bit per
// clock, amt times, then pulses done_tick with the result held on y.
module seq_rotator_lr #(
  parameter int N = 8,
  parameter int M = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [M-1:0] amt,
  input  logic         lr,
  output logic [N-1:0] y,
  output logic         ready,
  output logic         done_tick
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [M-1:0] CNT_ONE = M'(1);

  state_t       r_state;
  state_t       w_state_next;
  logic [N-1:0] r_y;
  logic [N-1:0] w_y_next;
  logic [M-1:0] r_count;
  logic [M-1:0] w_count_next;
  logic         r_dir;
  logic         w_dir_next;
  logic [N-1:0] w_rot_left;
  logic [N-1:0] w_rot_right;

  assign w_rot_left  = {r_y[N-2:0], r_y[N-1]};
  assign w_rot_right = {r_y[0], r_y[N-1:1]};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_y_next     = r_y;
    w_count_next = r_count;
    w_dir_next   = r_dir;
    ready        = 1'b0;
    done_tick    = 1'b0;

    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_y_next     = a;
          w_count_next = amt;
          w_dir_next   = lr;
          w_state_next = (amt == '0) ? DONE : SHIFT;
        end
      end

      SHIFT: begin
        w_y_next     = r_dir ? w_rot_left : w_rot_right;
        w_count_next = r_count - CNT_ONE;
        if (r_count == CNT_ONE) begin
          w_state_next = DONE;
        end
      end

      DONE: begin
        done_tick    = 1'b1;
        w_state_next = IDLE;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Datapath registers are reset so y reads zero while reset is asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_y     <= '0;
      r_count <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_y     <= w_y_next;
      r_count <= w_count_next;
      r_dir   <= w_dir_next;
    end
  end

  assign y = r_y;

endmodule

// File: tb/tb_seq_rotator_lr.sv
// Scoreboard bench for seq_rotator_lr: stimulus pushes expected result and
// done cycle; a monitor pops and compares on every done_tick.
module tb_seq_rotator_lr;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [2:0] amt;
  logic       lr;
  logic [7:0] y;
  logic       ready;
  logic       done_tick;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] y;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  seq_rotator_lr #(.N(8), .M(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .amt       (amt),
    .lr        (lr),
    .y         (y),
    .ready     (ready),
    .done_tick (done_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] rot(input logic [7:0] v, input logic [2:0] n, input logic l);
    logic [15:0] d;
    d = {v, v};
    d = l ? (d << n) : (d >> n);
    return l ? d[15:8] : d[7:0];
  endfunction

  task automatic finish_now();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Monitor: every done_tick must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done_tick) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_y", int'(y), int'(e.y));
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Returns at a falling edge with ready observed high.
  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!ready) begin
      n++;
      if (n > 50) begin
        check("ready_timeout", 0, 1);
        finish_now();
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 || !ready) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        check("drain_timeout", 0, 1);
        finish_now();
      end
    end
  endtask

  // One operation with start pulsed; leaves the bench at the falling edge
  // after acceptance, with inputs scrambled to prove they were captured.
  task automatic op(input logic [7:0] ta, input logic [2:0] tamt, input logic tlr,
                    input logic [7:0] ty);
    exp_t e;
    wait_ready();
    a = ta; amt = tamt; lr = tlr; start = 1'b1;
    @(posedge clk);
    e.y   = ty;
    e.cyc = cyc + 1 + int'(tamt);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a     = 8'($urandom);
    amt   = 3'($urandom);
    lr    = 1'($urandom);
    check("ready_low_after_start", int'(ready), 0);
  endtask

  initial begin
    int prev_t;
    int prev_amt;
    int t;
    exp_t e;

    reset = 1'b1; start = 1'b0; a = '0; amt = '0; lr = 1'b0;
    #1;
    check("reset_y", int'(y), 0);
    check("reset_ready", int'(ready), 1);
    check("reset_done", int'(done_tick), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    op(8'h96, 3'd3, 1'b0, 8'hD2);
    wait_drain();
    repeat (2) @(negedge clk);
    check("y_held_idle", int'(y), 8'hD2);

    op(8'h96, 3'd3, 1'b1, 8'hB4);
    wait_drain();

    op(8'h96, 3'd0, 1'b0, 8'h96);
    wait_drain();

    // start during SHIFT must be ignored.
    op(8'h96, 3'd7, 1'b1, 8'h4B);
    a = 8'hFF; amt = 3'd5; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (4) @(negedge clk);
    check("y_after_ignored_start", int'(y), 8'h4B);

    // Reset two cycles into an operation abandons it.
    op(8'h5A, 3'd6, 1'b0, 8'h69);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midop_reset_y", int'(y), 0);
    check("midop_reset_ready", int'(ready), 1);
    check("midop_reset_done", int'(done_tick), 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("y_zero_after_reset", int'(y), 0);

    op(8'h01, 3'd1, 1'b1, 8'h02);
    wait_drain();

    // start held high: back-to-back random operations, one IDLE cycle apart.
    prev_t = 0; prev_amt = 0;
    wait_ready();
    a = 8'($urandom); amt = 3'($urandom); lr = 1'($urandom); start = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk);
      t     = cyc + 1;
      e.y   = rot(a, amt, lr);
      e.cyc = t + int'(amt);
      exp_q.push_back(e);
      if (k > 0) check("idle_gap", t, prev_t + prev_amt + 2);
      prev_t   = t;
      prev_amt = int'(amt);
      if (k < 999) begin
        wait_ready();
        a = 8'($urandom); amt = 3'($urandom); lr = 1'($urandom);
      end
    end
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    finish_now();
  end

endmodule
